// File: rtl/tli4970_reader.sv
// tli4970_reader: periodic SPI readout sequencer for the TLI4970 current sensor.
// A free-running period counter starts one 16-bit mode-0 SPI frame per period
// (when enabled). Each frame is checked for even parity and message type 0.
// Good frames publish an offset-corrected signed current; bad ones are counted.
//
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   enable            gates frame starts (a frame in flight always completes)
//   spi_miso          sensor data, sampled on the clk edge that raises spi_sck
//   spi_cs_n, spi_sck SPI chip select (active low) and clock (idles low)
//   current           signed 13-bit current, holds last good value
//   current_valid     1-cycle pulse when current updates
//   frame_error       1-cycle pulse on a rejected frame
//   ocd               over-current flag of last good frame
//   raw_frame         last received frame, good or bad
//   error_count       rejected-frame count, saturating at 255
module tli4970_reader #(
  parameter int CLK_FREQ    = 32_000_000,
  parameter int SAMPLE_RATE = 500,
  parameter int SCK_DIV     = 16,
  parameter int CS_LEAD     = 2,
  parameter int CS_LAG      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic [12:0] current,
  output logic        current_valid,
  output logic        frame_error,
  output logic        ocd,
  output logic [15:0] raw_frame,
  output logic [7:0]  error_count
);

  localparam int P  = CLK_FREQ / SAMPLE_RATE;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LAG, CHECK} state_t;

  state_t        state, state_n;
  logic [15:0]   timer, timer_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [PW-1:0] per_cnt;
  logic          tick;
  logic [15:0]   shreg;
  logic          cs_n_d, sck_d;
  logic          frame_good;

  // Period counter runs regardless of FSM state so frame starts stay on a
  // fixed grid; ticks arriving outside IDLE are simply dropped.
  assign tick = (per_cnt == PW'(P - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) per_cnt <= '0;
    else          per_cnt <= tick ? '0 : per_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_n;
    end
  end

  // timer counts clocks within the current state; in SHIFT it spans one
  // full SCK period (low phase 0..SCK_DIV-1, high phase SCK_DIV..2*SCK_DIV-1).
  always_comb begin
    state_n = state;
    timer_n = timer + 16'd1;
    bit_n   = bit_cnt;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (tick && enable) state_n = LEAD;
      end
      LEAD: begin
        if (timer == 16'(CS_LEAD - 1)) begin
          state_n = SHIFT;
          timer_n = '0;
          bit_n   = 4'd15;
        end
      end
      SHIFT: begin
        if (timer == 16'(2 * SCK_DIV - 1)) begin
          timer_n = '0;
          if (bit_cnt == 4'd0) state_n = LAG;
          else                 bit_n   = bit_cnt - 4'd1;
        end
      end
      LAG: begin
        if (timer == 16'(CS_LAG - 1)) begin
          state_n = CHECK;
          timer_n = '0;
        end
      end
      CHECK: begin
        state_n = IDLE;
        timer_n = '0;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // SPI pins are registered from the next-state view so they line up exactly
  // with the registered state (CS low for precisely LEAD+SHIFT+LAG clocks).
  assign cs_n_d = !(state_n inside {LEAD, SHIFT, LAG});
  assign sck_d  = (state_n == SHIFT) && (timer_n >= 16'(SCK_DIV));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      shreg    <= '0;
    end else begin
      spi_cs_n <= cs_n_d;
      spi_sck  <= sck_d;
      // Sample on the edge that raises SCK; the sensor launched the bit on
      // the previous falling edge, so it has been stable for SCK_DIV clocks.
      if (sck_d && !spi_sck) shreg <= {shreg[14:0], spi_miso};
    end
  end

  // Even overall parity and message type 0 (current reading).
  assign frame_good = ~(^shreg) & ~shreg[15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current       <= '0;
      current_valid <= 1'b0;
      frame_error   <= 1'b0;
      ocd           <= 1'b0;
      raw_frame     <= '0;
      error_count   <= '0;
    end else begin
      current_valid <= 1'b0;
      frame_error   <= 1'b0;
      if (state == CHECK) begin
        raw_frame <= shreg;
        if (frame_good) begin
          // Offset binary minus 4096 is just an MSB flip.
          current       <= {~shreg[12], shreg[11:0]};
          ocd           <= shreg[13];
          current_valid <= 1'b1;
        end else begin
          frame_error <= 1'b1;
          if (error_count != 8'hFF) error_count <= error_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/tli4970_reader.md
# tli4970_reader

Self-contained readout sequencer for the TLI4970 current sensor on the motor board. It generates the SPI chip-select and clock at a fixed sample rate and shifts in one 16-bit frame per period. It checks each frame's parity and message type, then publishes a signed, offset-corrected current value. The output feeds the `control_mode==3` input of the motor controller's state mux and the `current` field reported by the comms block, replacing the ad-hoc wren/delay-counter logic at top level.

## Interface
Parameters:
- `CLK_FREQ`, 32_000_000: system clock frequency in Hz.
- `SAMPLE_RATE`, 500: frames per second. Period `P = CLK_FREQ/SAMPLE_RATE` clocks. `P` must be ≥ frame length + 2.
- `SCK_DIV`, 16: clocks per SCK half-period. The default gives 1 MHz SCK.
- `CS_LEAD`, 2: clocks from `spi_cs_n` falling to the first SCK low phase.
- `CS_LAG`, 2: clocks from the last SCK falling edge to `spi_cs_n` rising.

Ports:
- `clk`  in  1  system clock (clk32MHz domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, period ticks do not start frames.
- `spi_miso`  in  1  sensor data. Externally synchronous to SCK; sampled in the `clk` domain.
- `spi_cs_n`  out  1  sensor chip select, active low.
- `spi_sck`  out  1  SPI clock, mode 0 (idles low).
- `current`  out  13  signed current, two's complement; holds the last good value.
- `current_valid`  out  1  one-cycle pulse when `current` updates.
- `frame_error`  out  1  one-cycle pulse on a rejected frame.
- `ocd`  out  1  over-current flag from the last good frame.
- `raw_frame`  out  16  last received frame, good or bad.
- `error_count`  out  8  rejected-frame count, saturates at 255.

## Operation
- **Period counter:** free-runs 0..P-1 from reset, independent of `enable` and of FSM state. It emits a tick when the counter is at P-1.
- **FSM states:** IDLE, LEAD, SHIFT, LAG, CHECK.
- **IDLE:** on a tick with `enable`=1, drive `spi_cs_n` low and go to LEAD. Ticks in any other state are ignored.
- **LEAD:** wait `CS_LEAD` clocks, then go to SHIFT with a bit counter of 15.
- **SHIFT:** per bit, SCK is low for `SCK_DIV` clocks, then high for `SCK_DIV` clocks.
  - On the clock edge where `spi_sck` goes 0→1, shift `spi_miso` into bit 0 of the shift register (MSB first).
  - After the 16th high phase, SCK returns low and the FSM goes to LAG.
- **LAG:** wait `CS_LAG` clocks, drive `spi_cs_n` high, go to CHECK.
- **CHECK:** lasts one cycle. It loads `raw_frame` and evaluates the frame, then returns to IDLE.
- **Frame format:** bit 15 = message type (0 = current), bit 14 = parity, bit 13 = OCD, bits 12:0 = current in offset binary (4096 = 0 A).
- **Good frame:** the XOR of all 16 bits is 0 and bit 15 = 0. On a good frame:
  - `current` ← `{~f[12], f[11:0]}`, which equals raw − 4096.
  - `ocd` ← `f[13]`.
  - `current_valid` pulses.
- **Rejected frame:** anything else. `frame_error` pulses and `error_count` increments, stopping at 255. `current` and `ocd` hold their values.
- **Enable dropped mid-frame:** the frame completes normally.

## Timing
- **Reset values:** `spi_cs_n`=1, `spi_sck`=0, `current`=0, `current_valid`=0, `frame_error`=0, `ocd`=0, `raw_frame`=0, `error_count`=0, period counter=0, FSM=IDLE.
- **Reset mid-frame:** `spi_cs_n` rises and `spi_sck` falls asynchronously with `reset_n`, and the partial frame is discarded.
- **Frame start:** `spi_cs_n` falls on the clock after the tick cycle.
- **Frame length:** from `spi_cs_n` low to `spi_cs_n` high is `CS_LEAD + 32*SCK_DIV + CS_LAG` clocks (516 with defaults).
- **Output latency:** `current`, `current_valid`, and `frame_error` change 1 clock after `spi_cs_n` rises. `current` and `current_valid` change in the same cycle.
- **Exclusivity:** `current_valid` and `frame_error` are never high together.
- **Outputs:** all outputs are registered, with no combinational path from `spi_miso`.

## Test plan
- Sensor model returns 0x1064 (parity OK) → `current`=+100, `current_valid` pulses once, `ocd`=0, `error_count`=0.
- Sensor returns 0x0F9C → `current`=−100 (13'h1F9C); then 0x5000 → `current`=0.
- Sensor returns 0x1065 (bad parity) → `frame_error` pulse, `raw_frame`=0x1065, `current` holds −100/0, `error_count`=1.
- Sensor returns 0xC000 (status message, parity OK) → rejected and `error_count` increments. Then 0x7064 → `current`=+100, `ocd`=1.
- Check SCK and CS shape: 16 SCK pulses, each high for 16 clocks, 516 clocks of CS low, a frame start every 64000 clocks. With `enable`=0, no CS activity. Force 300 bad frames → `error_count`=255.
- Assert `reset_n` low at bit 7 of a frame → `spi_cs_n`=1 and `spi_sck`=0 immediately, all outputs at reset values, and the next frame starts 64000 clocks after release.
